cmsdk_ahb_to_fpga_sram: RTL and testbench

AHB-Lite slave that drives the pipelined FPGA block-RAM SRAM port. It is the initiator side of the CLK/ADDR/WDATA/WREN/CS/RDATA interface. Reads complete with zero wait states by using the RAM's 1-cycle read latency. Writes are posted into a one-entry write buffer and committed on the next cycle with no SRAM read; reads that hit the buffer have their bytes merged in.

---
 rtl/cmsdk_ahb_sram_pkg.sv | 30 +++
 rtl/cmsdk_ahb_sram_wbuf.sv | 73 +++++++
 rtl/cmsdk_ahb_to_fpga_sram.sv | 106 ++++++++++
 tb/tb_cmsdk_ahb_to_fpga_sram.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_ahb_sram_pkg.sv
// cmsdk_ahb_sram_pkg: shared AHB encodings, byte-lane mask helper and error-FSM states
//   Used by cmsdk_ahb_to_fpga_sram and cmsdk_ahb_sram_wbuf.
package cmsdk_ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } err_state_e;

    // Byte lanes touched by a transfer; anything word-sized or larger covers the whole word.
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_BYTE ? 4'b0001 << a :
               size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
        return (size == HSIZE_HALF && a[0]) || (size == HSIZE_WORD && a != 2'b00) || size > HSIZE_WORD;
    endfunction

endpackage

// File: rtl/cmsdk_ahb_sram_wbuf.sv
// cmsdk_ahb_sram_wbuf: one-entry posted write buffer with commit control and read-data merge
//   clk_i, rst_n_i      : clock, async active-low reset
//   wr_accept_i         : write address phase accepted this cycle (loads the buffer)
//   rd_accept_i         : read address phase accepted this cycle (defers any commit)
//   wr_addr_i/wr_mask_i : word address and byte lanes of the accepted write
//   hwdata_i            : AHB write data (valid in the write data phase)
//   rd_addr_i           : registered word address of the read in data phase
//   sram_rdata_i        : SRAM read data
//   commit_o            : buffer is being written to the SRAM this cycle
//   buf_addr_o/mask_o   : address and byte enables of the buffered write
//   wdata_o             : SRAM write data
//   merged_o            : SRAM read data with buffered bytes substituted
module cmsdk_ahb_sram_wbuf
    import cmsdk_ahb_sram_pkg::*;
#(
    parameter int WW = 14
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_accept_i,
    input  logic          rd_accept_i,
    input  logic [WW-1:0] wr_addr_i,
    input  logic [3:0]    wr_mask_i,
    input  logic [31:0]   hwdata_i,
    input  logic [WW-1:0] rd_addr_i,
    input  logic [31:0]   sram_rdata_i,
    output logic          commit_o,
    output logic [WW-1:0] buf_addr_o,
    output logic [3:0]    buf_mask_o,
    output logic [31:0]   wdata_o,
    output logic [31:0]   merged_o
);

    logic          buf_valid_q, buf_valid_d;
    logic          buf_dphase_q;
    logic [WW-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]    buf_mask_q, buf_mask_d;
    logic [31:0]   buf_data_q, buf_data_d;
    logic          hit;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            buf_valid_q  <= 1'b0;
            buf_dphase_q <= 1'b0;
            buf_addr_q   <= '0;
            buf_mask_q   <= '0;
            buf_data_q   <= '0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_dphase_q <= wr_accept_i;
            buf_addr_q   <= buf_addr_d;
            buf_mask_q   <= buf_mask_d;
            buf_data_q   <= buf_data_d;
        end

    // A read owns the SRAM port, so the buffered write waits and stays visible to the merge.
    always_comb begin
        commit_o    = buf_valid_q & ~rd_accept_i;
        buf_valid_d = wr_accept_i | (buf_valid_q & ~commit_o);
        buf_addr_d  = wr_accept_i ? wr_addr_i : buf_addr_q;
        buf_mask_d  = wr_accept_i ? wr_mask_i : buf_mask_q;
        buf_data_d  = buf_dphase_q ? hwdata_i : buf_data_q;
        wdata_o     = commit_o & buf_dphase_q ? hwdata_i : buf_data_q;
        hit         = buf_valid_q & (buf_addr_q == rd_addr_i);
        merged_o    = sram_rdata_i;
        for (int i = 0; i < 4; i++)
            merged_o[8*i +: 8] = hit & buf_mask_q[i] ? buf_data_q[8*i +: 8] : sram_rdata_i[8*i +: 8];
    end

    assign buf_addr_o = buf_addr_q;
    assign buf_mask_o = buf_mask_q;

endmodule

// File: rtl/cmsdk_ahb_to_fpga_sram.sv
// cmsdk_ahb_to_fpga_sram: zero-wait AHB-Lite slave driving a 1-cycle-latency FPGA block-RAM port
//   HCLK, HRESETn          : clock (also the SRAM clock), async active-low reset
//   HSEL, HREADY, HTRANS,
//   HSIZE, HWRITE, HADDR,
//   HWDATA                 : AHB-Lite slave inputs
//   HREADYOUT, HRESP,
//   HRDATA                 : AHB-Lite slave outputs
//   SRAMRDATA              : SRAM read data, one cycle after the address
//   SRAMADDR, SRAMWDATA,
//   SRAMWEN, SRAMCS        : SRAM address, write data, byte write enables, chip select
//   Optional macro AHB_SRAM_ALIGN_CHECK_EN: misaligned transfers get a two-cycle ERROR response.
module cmsdk_ahb_to_fpga_sram
    import cmsdk_ahb_sram_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWEN,
    output logic          SRAMCS
);

    logic          accept, xfer_ok, rd_accept, wr_accept;
    logic          rd_dphase_q;
    logic [AW-3:0] rd_addr_q, rd_addr_d;
    logic          commit;
    logic [AW-3:0] buf_addr;
    logic [3:0]    buf_mask;
    logic [31:0]   merged;

    // Gating with HRESETn keeps the SRAM strobes quiet for the whole reset window.
    assign accept = HRESETn & HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

`ifdef AHB_SRAM_ALIGN_CHECK_EN
    err_state_e err_q, err_d;
    logic       mis;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) err_q <= ST_OKAY;
        else          err_q <= err_d;

    always_comb begin
        mis     = misaligned(HSIZE, HADDR[1:0]);
        xfer_ok = accept & ~mis;
        err_d   = err_q == ST_ERR1 ? ST_ERR2 : (accept & mis) ? ST_ERR1 : ST_OKAY;
    end

    assign HREADYOUT = err_q != ST_ERR1;
    assign HRESP     = err_q != ST_OKAY;
`else
    assign xfer_ok   = accept;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

    assign rd_accept = xfer_ok & ~HWRITE;
    assign wr_accept = xfer_ok & HWRITE;
    assign rd_addr_d = rd_accept ? HADDR[AW-1:2] : rd_addr_q;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            rd_dphase_q <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            rd_dphase_q <= rd_accept;
            rd_addr_q   <= rd_addr_d;
        end

    cmsdk_ahb_sram_wbuf #(
        .WW(AW-2)
    ) u_wbuf (
        .clk_i       (HCLK),
        .rst_n_i     (HRESETn),
        .wr_accept_i (wr_accept),
        .rd_accept_i (rd_accept),
        .wr_addr_i   (HADDR[AW-1:2]),
        .wr_mask_i   (byte_mask(HSIZE, HADDR[1:0])),
        .hwdata_i    (HWDATA),
        .rd_addr_i   (rd_addr_q),
        .sram_rdata_i(SRAMRDATA),
        .commit_o    (commit),
        .buf_addr_o  (buf_addr),
        .buf_mask_o  (buf_mask),
        .wdata_o     (SRAMWDATA),
        .merged_o    (merged)
    );

    assign SRAMADDR = rd_accept ? HADDR[AW-1:2] : buf_addr;
    assign SRAMCS   = rd_accept | commit;
    assign SRAMWEN  = commit ? buf_mask : 4'b0000;
    assign HRDATA   = rd_dphase_q ? merged : 32'h0;

endmodule

// File: tb/tb_cmsdk_ahb_to_fpga_sram.sv
// tb_cmsdk_ahb_to_fpga_sram: directed + random scoreboard bench with a behavioural RAM and byte-level reference memory
module tb_cmsdk_ahb_to_fpga_sram;
    import cmsdk_ahb_sram_pkg::*;

    localparam int AW = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL, HREADY, HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [AW-1:0] HADDR;
    logic [31:0]   HWDATA;
    logic          HREADYOUT, HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   SRAMRDATA;
    logic [AW-3:0] SRAMADDR;
    logic [31:0]   SRAMWDATA;
    logic [3:0]    SRAMWEN;
    logic          SRAMCS;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    cmsdk_ahb_to_fpga_sram #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
        .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        logic [31:0] v;
        v = 32'h9E3779B9 * 32'(a + 1);
        return a == 8 ? 32'h11223344 : v;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (wen[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // Behavioural block RAM: registered read, byte-enabled write, unwritten words show init_val.
    logic [31:0] sram [0:255];
    logic        written [0:255];
    logic        clr;
    logic [7:0]  sidx;
    assign sidx = SRAMADDR[7:0];

    always @(posedge HCLK) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (SRAMCS) begin
            if (SRAMWEN == 4'b0000) SRAMRDATA <= written[sidx] ? sram[sidx] : init_val(int'(sidx));
            else begin
                sram[sidx]    <= lanes(written[sidx] ? sram[sidx] : init_val(int'(sidx)), SRAMWDATA, SRAMWEN);
                written[sidx] <= 1'b1;
            end
        end
    end

    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q [$];
    logic [31:0] pend_wdata;
    logic        tb_rd;

    // One bus cycle: HWDATA carries the previous write's data; upd=0 leaves the reference untouched.
    task automatic issue(input logic act, input logic wr, input logic [2:0] size, input logic [15:0] addr,
                         input logic [31:0] data, input logic upd, input logic sb);
        int nb, first, w;
        @(posedge HCLK);
        #1;
        HWDATA = pend_wdata;
        HSEL   = act;
        HTRANS = act ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        tb_rd  = act & ~wr & sb;
        pend_wdata = $urandom();
        w = int'(addr[9:2]);
        if (act & wr) begin
            pend_wdata = data;
            nb = 1 << size;
            if (nb > 4) nb = 4;
            first = int'(addr[1:0]) & ~(nb - 1);
            if (upd) for (int k = first; k < first + nb; k++) ref_mem[w][8*k +: 8] = data[8*k +: 8];
        end
        if (act & ~wr & sb) exp_q.push_back(ref_mem[w]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: a read's data phase is the cycle after it was accepted.
    logic        rd_ph;
    logic [31:0] mon_e;

    always @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) rd_ph <= 1'b0;
        else          rd_ph <= tb_rd & HREADY;

    always @(negedge HCLK)
        if (HRESETn) begin
            if (rd_ph) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got read data %h with no expected entry", HRDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata", HRDATA, mon_e);
                    chk("rd_okay_ready", {30'h0, HRESP, HREADYOUT}, 32'h1);
                end
            end else chk("rdata_idle_zero", HRDATA, 32'h0);
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] d [0:3];
        int op, w, sz, off;
        HSEL = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HSIZE = 0; HADDR = 0; HWDATA = 0;
        pend_wdata = 0; tb_rd = 0; clr = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        #2;
        chk("reset_ctrl", {25'h0, HREADYOUT, HRESP, SRAMCS, SRAMWEN}, {25'h0, 7'b1000000});
        chk("reset_hrdata", HRDATA, 32'h0);
        repeat (3) @(posedge HCLK);
        #3;
        clr = 0;
        HRESETn = 1;

        // word write committed in its data phase
        issue(1, 1, 3'd2, 16'h10, 32'hDEADBEEF, 1, 0);
        issue(0, 0, 3'd0, 16'h0, 32'h0, 0, 0);
        @(negedge HCLK);
        chk("w_wen", {28'h0, SRAMWEN}, 32'hF);
        chk("w_addr", {18'h0, SRAMADDR}, 32'h4);
        chk("w_wdata", SRAMWDATA, 32'hDEADBEEF);
        issue(1, 0, 3'd2, 16'h10, 32'h0, 0, 1);
        idle(1);

        // byte write followed immediately by a read of the same word
        issue(1, 1, 3'd0, 16'h21, 32'h0000AB00, 1, 0);
        issue(1, 0, 3'd2, 16'h20, 32'h0, 0, 1);
        @(negedge HCLK);
        chk("rd_cs_wen", {27'h0, SRAMCS, SRAMWEN}, 32'h10);
        chk("rd_addr", {18'h0, SRAMADDR}, 32'h8);
        idle(1);
        @(negedge HCLK);
        chk("merge_hrdata", HRDATA, 32'h1122AB44);
        chk("byte_wen", {28'h0, SRAMWEN}, 32'h2);
        chk("byte_wdata", {24'h0, SRAMWDATA[15:8]}, 32'hAB);
        idle(1);

        // back-to-back writes, each committing in the next address phase
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom();
            issue(1, 1, 3'd2, 16'(4 * k), d[k], 1, 0);
            @(negedge HCLK);
            chk("b2b_ready", {31'h0, HREADYOUT}, 32'h1);
            if (k > 0) begin
                chk("b2b_wen", {28'h0, SRAMWEN}, 32'hF);
                chk("b2b_addr", {18'h0, SRAMADDR}, 32'(k - 1));
                chk("b2b_wdata", SRAMWDATA, d[k-1]);
            end
        end
        for (int k = 0; k < 4; k++) issue(1, 0, 3'd2, 16'(4 * k), 32'h0, 0, 1);
        idle(2);

        // halfword write to the upper lanes
        issue(1, 1, 3'd1, 16'h6, 32'hCAFE0000, 1, 0);
        issue(0, 0, 3'd0, 16'h0, 32'h0, 0, 0);
        @(negedge HCLK);
        chk("half_wen", {28'h0, SRAMWEN}, 32'hC);
        chk("half_addr", {18'h0, SRAMADDR}, 32'h1);
        chk("half_wdata", {16'h0, SRAMWDATA[31:16]}, 32'hCAFE);
        idle(2);

`ifdef AHB_SRAM_ALIGN_CHECK_EN
        issue(1, 0, 3'd2, 16'h2, 32'h0, 0, 0);
        @(negedge HCLK);
        chk("mis_no_cs", {31'h0, SRAMCS}, 32'h0);
        idle(1);
        @(negedge HCLK);
        chk("err1_rdy_resp", {30'h0, HREADYOUT, HRESP}, 32'h1);
        chk("err1_no_cs", {31'h0, SRAMCS}, 32'h0);
        idle(1);
        @(negedge HCLK);
        chk("err2_rdy_resp", {30'h0, HREADYOUT, HRESP}, 32'h3);
        idle(1);
        @(negedge HCLK);
        chk("err_done", {30'h0, HREADYOUT, HRESP}, 32'h2);
        issue(1, 1, 3'd2, 16'h6, 32'h12345678, 0, 0);
        idle(4);
        issue(1, 0, 3'd2, 16'h4, 32'h0, 0, 1);
        idle(1);
`else
        issue(1, 0, 3'd2, 16'h2, 32'h0, 0, 1);
        @(negedge HCLK);
        chk("unal_rd_cs", {31'h0, SRAMCS}, 32'h1);
        chk("unal_rd_addr", {18'h0, SRAMADDR}, 32'h0);
        issue(1, 1, 3'd2, 16'h2, 32'h0BADF00D, 1, 0);
        @(negedge HCLK);
        chk("unal_rdy_resp", {30'h0, HREADYOUT, HRESP}, 32'h2);
        idle(1);
        @(negedge HCLK);
        chk("unal_wen", {28'h0, SRAMWEN}, 32'hF);
        issue(1, 0, 3'd2, 16'h0, 32'h0, 0, 1);
        idle(1);
`endif

        // reset in the middle of a write's data phase discards the buffered write
        issue(1, 1, 3'd2, 16'h0, 32'h55AA55AA, 0, 0);
        issue(0, 0, 3'd0, 16'h0, 32'h0, 0, 0);
        #2;
        HRESETn = 0;
        #1;
        chk("mid_reset_ctrl", {25'h0, HREADYOUT, HRESP, SRAMCS, SRAMWEN}, {25'h0, 7'b1000000});
        chk("mid_reset_hrdata", HRDATA, 32'h0);
        @(posedge HCLK);
        #3;
        HRESETn = 1;
        issue(1, 0, 3'd2, 16'h0, 32'h0, 0, 1);
        idle(1);

        // random traffic over a small window so buffer hits are frequent
        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 2);
            w   = $urandom_range(0, 15);
            sz  = $urandom_range(0, 2);
            off = $urandom_range(0, 3) & ~((1 << sz) - 1);
            if (op == 0) idle(1);
            else issue(1, op == 1, 3'(sz), 16'(4 * w + off), $urandom(), 1, 1);
        end
        idle(3);
        for (int k = 0; k < 16; k++) issue(1, 0, 3'd2, 16'(4 * k), 32'h0, 0, 1);
        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
